instr_fetch32: RTL and testbench

INSTR_FETCH32 -- requirements
Module: instr_fetch32

---
 rtl/instr_fetch32.sv | 89 ++++++++
 tb/tb_instr_fetch32.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch32.sv
// Instruction fetch: PC register, next-PC select (jr/j/jal/beq/bne), word-addressed
// instruction memory with a load port. Optional `IFETCH_STALL_EN adds a stall input.
module instr_fetch32 #(
  parameter int          IMEM_AW  = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        Add_result,
  input  logic [31:0]        Read_data_1,
  input  logic               Branch,
  input  logic               nBranch,
  input  logic               Jmp,
  input  logic               Jal,
  input  logic               Jrn,
  input  logic               Zero,
  input  logic               prog_we,
  input  logic [IMEM_AW-1:0] prog_addr,
  input  logic [31:0]        prog_data,
`ifdef IFETCH_STALL_EN
  input  logic               stall,
`endif
  output logic [31:0]        Instruction,
  output logic [31:0]        PC,
  output logic [31:0]        PC_plus_4,
  output logic [31:0]        opcplus4,
  output logic               fetch_err
);

  localparam int IMEM_DEPTH = 1 << IMEM_AW;

  logic [31:0] imem [0:IMEM_DEPTH-1];
  logic [31:0] next_pc;
  logic        br_taken;
  logic        target_misaligned;
  logic        hold;

`ifdef IFETCH_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  // Upper PC bits are ignored, so fetch wraps around the memory.
  assign Instruction = imem[PC[IMEM_AW+1:2]];
  assign PC_plus_4   = PC + 32'd4;
  assign opcplus4    = PC_plus_4;

  assign br_taken = (Branch & Zero) | (nBranch & ~Zero);

  always_comb begin
    next_pc           = PC_plus_4;
    target_misaligned = 1'b0;
    if (Jrn) begin
      next_pc           = {Read_data_1[31:2], 2'b00};
      target_misaligned = |Read_data_1[1:0];
    end else if (Jmp | Jal) begin
      next_pc = {PC_plus_4[31:28], Instruction[25:0], 2'b00};
    end else if (br_taken) begin
      next_pc           = {Add_result[31:2], 2'b00};
      target_misaligned = |Add_result[1:0];
    end
  end

  // Memory has no reset so a loaded program survives a reset pulse.
  always_ff @(posedge clock) begin
    if (prog_we) begin
      imem[prog_addr] <= prog_data;
    end
  end

  // PC stage: loading the program parks PC at the reset vector.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      PC        <= RESET_PC;
      fetch_err <= 1'b0;
    end else if (!hold) begin
      if (prog_we) begin
        PC <= RESET_PC;
      end else begin
        PC <= next_pc;
        if (target_misaligned) begin
          fetch_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch32.sv
// Directed bench for instr_fetch32: expected values queued at drive time, popped at check.
module tb_instr_fetch32;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] Add_result, Read_data_1;
  logic        Branch, nBranch, Jmp, Jal, Jrn, Zero;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;
`ifdef IFETCH_STALL_EN
  logic        stall;
`endif
  logic [31:0] Instruction, PC, PC_plus_4, opcplus4;
  logic        fetch_err;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  instr_fetch32 #(.IMEM_AW(6), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset),
    .Add_result(Add_result), .Read_data_1(Read_data_1),
    .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jrn(Jrn), .Zero(Zero),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
`ifdef IFETCH_STALL_EN
    .stall(stall),
`endif
    .Instruction(Instruction), .PC(PC), .PC_plus_4(PC_plus_4),
    .opcplus4(opcplus4), .fetch_err(fetch_err)
  );

  always #5 clock = ~clock;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%h expected=<queued value>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_ctl();
    Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jrn = 0; Zero = 0;
    Add_result = 0; Read_data_1 = 0;
  endtask

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    tick();
  endtask

  initial begin
    reset = 0;
    clear_ctl();
    prog_we = 0; prog_addr = 0; prog_data = 0;
`ifdef IFETCH_STALL_EN
    stall = 0;
`endif
    #2;
    push("reset_pc", 32'h0);        check(PC);
    push("reset_err", 32'h0);       check({31'b0, fetch_err});

    load(6'd0,  32'h00431820);
    load(6'd1,  32'h20E38037);
    load(6'd5,  32'h0C000010);
    load(6'd20, 32'h08000008);
    load(6'd63, 32'hCAFE0063);
    prog_we = 0;
    reset = 1;
    #1;
    push("rel_pc", 32'h0);          check(PC);
    push("rel_instr", 32'h00431820); check(Instruction);
    push("rel_pc4", 32'h4);         check(PC_plus_4);

    tick();
    push("seq_pc", 32'h4);          check(PC);
    push("seq_instr", 32'h20E38037); check(Instruction);

    Branch = 1; Zero = 1; Add_result = 32'h14;
    tick();
    push("beq_to14", 32'h14);       check(PC);
    push("instr_at14", 32'h0C000010); check(Instruction);

    clear_ctl(); Jal = 1;
    #1;
    push("jal_link", 32'h18);       check(opcplus4);
    tick();
    push("jal_pc", 32'h40);         check(PC);

    clear_ctl(); Branch = 1; Zero = 1; Add_result = 32'h20;
    tick();
    push("beq_taken", 32'h20);      check(PC);

    clear_ctl(); Branch = 1; Zero = 0; Add_result = 32'h80;
    tick();
    push("beq_not_taken", 32'h24);  check(PC);

    clear_ctl(); nBranch = 1; Zero = 0; Add_result = 32'h30;
    tick();
    push("bne_taken", 32'h30);      check(PC);

    clear_ctl(); Branch = 1; nBranch = 1; Zero = 0; Add_result = 32'h50;
    tick();
    push("both_branch", 32'h50);    check(PC);

    // j at 0x50 holds target field 0x8 -> 0x20, and must beat a taken beq
    clear_ctl(); Jmp = 1; Branch = 1; Zero = 1; Add_result = 32'h80;
    tick();
    push("j_over_beq", 32'h20);     check(PC);

    clear_ctl(); Jrn = 1; Read_data_1 = 32'h2E; Branch = 1; Zero = 1; Add_result = 32'h80;
    tick();
    push("jr_pc", 32'h2C);          check(PC);
    push("jr_err", 32'h1);          check({31'b0, fetch_err});

    clear_ctl();
    tick();
    push("err_sticky_pc", 32'h30);  check(PC);
    push("err_sticky", 32'h1);      check({31'b0, fetch_err});

    Branch = 1; Zero = 1; Add_result = 32'hFC;
    tick();
    push("pc_fc", 32'hFC);          check(PC);
    push("instr_63", 32'hCAFE0063); check(Instruction);

    clear_ctl();
    tick();
    push("wrap_pc", 32'h100);       check(PC);
    push("wrap_instr", 32'h00431820); check(Instruction);

    prog_we = 1; prog_addr = 6'd0; prog_data = 32'hDEADBEEF;
    tick();
    push("prog_hold_pc", 32'h0);    check(PC);
    push("prog_write_thru", 32'hDEADBEEF); check(Instruction);

    prog_we = 0;
    tick();
    tick();
    push("resume_pc", 32'h8);       check(PC);

`ifdef IFETCH_STALL_EN
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      push("stall_hold", 32'h8);    check(PC);
    end
    stall = 0;
    tick();
    push("stall_release", 32'hC);   check(PC);
`endif

    push("err_before_rst", 32'h1);  check({31'b0, fetch_err});
    #2;
    reset = 0;
    #1;
    push("async_rst_pc", 32'h0);    check(PC);
    push("async_rst_pc4", 32'h4);   check(PC_plus_4);
    push("async_rst_err", 32'h0);   check({31'b0, fetch_err});
    push("mem_persist", 32'hDEADBEEF); check(Instruction);

    tick();
    reset = 1;
    tick();
    push("post_rst_pc", 32'h4);     check(PC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
